// File: rtl/multifun_sched.sv
// multifun_sched: round-robin scheduler in front of one shared bitwise
// multifunction unit, with lockable bursts and a registered response port.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req[NREQ]           per-requester request
//   lock[NREQ]          per-requester burst request (qualified by req)
//   sel[2*NREQ]         function select, requester i at [2i+1:2i]
//   a, b[W*NREQ]        operands, requester i at [W*i+W-1:W*i]
//   gnt[NREQ]           one-hot combinational grant
//   rsp_valid/id/f      registered response, held under backpressure
//   rsp_ready           consumer accepts the response
module multifun_sched #(
  parameter int NREQ     = 4,
  parameter int W        = 4,
  parameter int MAXBURST = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           lock,
  input  logic [2*NREQ-1:0]         sel,
  input  logic [W*NREQ-1:0]         a,
  input  logic [W*NREQ-1:0]         b,
  output logic [NREQ-1:0]           gnt,
  output logic                      rsp_valid,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [W-1:0]              rsp_f,
  input  logic                      rsp_ready
);
  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(MAXBURST) + 1;

  typedef enum logic {ARB, BURST} state_t;

  logic [NREQ-1:0][1:0]   sel_v;
  logic [NREQ-1:0][W-1:0] a_v, b_v;
  assign sel_v = sel;
  assign a_v   = a;
  assign b_v   = b;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d, own_q, own_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic            can_issue, gnt_any;
  logic [IW-1:0]   gnt_idx, idx;
  logic [IW:0]     s;
  logic [NREQ-1:0] excl;
  logic [W-1:0]    f;

  assign can_issue = !rsp_valid || rsp_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    bcnt_d  = bcnt_q;
    gnt_any = 1'b0;
    gnt_idx = '0;
    excl    = '0;
    s       = '0;
    idx     = '0;
    // Reset gating keeps gnt quiet while rst_n is low even with req high.
    if (rst_n && can_issue) begin
      if (state_q == BURST && req[own_q] && lock[own_q] && bcnt_q < BW'(MAXBURST)) begin
        // Burst grants leave ptr alone; it already points past the owner.
        gnt_any = 1'b1;
        gnt_idx = own_q;
        bcnt_d  = bcnt_q + 1'b1;
      end else begin
        state_d = ARB;
        // Only an exhausted burst forfeits the owner's chance this cycle.
        if (state_q == BURST && bcnt_q == BW'(MAXBURST)) excl[own_q] = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
          s = {1'b0, ptr_q} + (IW+1)'(k);
          if (s >= (IW+1)'(NREQ)) s = s - (IW+1)'(NREQ);
          idx = s[IW-1:0];
          if (!gnt_any && req[idx] && !excl[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = idx;
          end
        end
        if (gnt_any) begin
          ptr_d = (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
          if (lock[gnt_idx]) begin
            state_d = BURST;
            own_d   = gnt_idx;
            bcnt_d  = BW'(1);
          end
        end
      end
    end
  end

  assign gnt = gnt_any ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;

  // The single shared function unit, fed by the granted requester.
  always_comb begin
    unique case (sel_v[gnt_idx])
      2'b00:   f = a_v[gnt_idx] & b_v[gnt_idx];
      2'b01:   f = a_v[gnt_idx] | b_v[gnt_idx];
      2'b10:   f = a_v[gnt_idx] ^ b_v[gnt_idx];
      default: f = ~(a_v[gnt_idx] & b_v[gnt_idx]);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB;
      ptr_q     <= '0;
      own_q     <= '0;
      bcnt_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_f     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      bcnt_q  <= bcnt_d;
      if (gnt_any) begin
        rsp_valid <= 1'b1;
        rsp_id    <= gnt_idx;
        rsp_f     <= f;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end
endmodule
